// File: rtl/invariant_monitor.sv
`default_nettype none
// ============================================================================
// Module   : invariant_monitor
// Purpose  : Sticky checker for Sodor invariant cond/arg0 pairs. It records the
//            first failing invariant, its sample timestamp and the count of
//            violating sampled cycles.
// Options  : define INV_MON_HALT_EN to drive the zero-latency halt output.
// Revision : 1.0 - initial release
// ============================================================================
module invariant_monitor #(
    parameter int NUM_INV = 10,
    parameter int WARMUP  = 2,
    parameter int CNT_W   = 16,
    parameter int CYC_W   = 32,
    localparam int ID_W   = (NUM_INV > 1) ? $clog2(NUM_INV) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_INV-1:0] inv_cond,
    input  logic [NUM_INV-1:0] inv_arg0,
    input  logic [NUM_INV-1:0] inv_mask,
    input  logic               sample,
    input  logic               clear,
    output logic               armed,
    output logic               fail,
    output logic               viol_pulse,
    output logic [NUM_INV-1:0] viol_vec,
    output logic [ID_W-1:0]    first_id,
    output logic [CYC_W-1:0]   first_cycle,
    output logic [CNT_W-1:0]   viol_count,
    output logic               halt
);

    localparam int c_WC_W      = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int c_WARM_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;

    localparam logic [1:0] c_ST_WARMUP = 2'd0;
    localparam logic [1:0] c_ST_ARMED  = 2'd1;
    localparam logic [1:0] c_ST_FAILED = 2'd2;
    localparam logic [1:0] c_ST_INIT   = (WARMUP == 0) ? c_ST_ARMED : c_ST_WARMUP;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_WC_W-1:0]  r_warm_cnt;
    logic [CYC_W-1:0]   r_sample_cnt;
    logic               r_viol_pulse;
    logic [NUM_INV-1:0] r_viol_vec;
    logic [ID_W-1:0]    r_first_id;
    logic [CYC_W-1:0]   r_first_cycle;
    logic [CNT_W-1:0]   r_viol_count;

    logic [NUM_INV-1:0] w_hit_vec;
    logic               w_hit;
    logic               w_live;
    logic               w_warm_done;
    logic               w_take;
    logic               w_clr;
    logic [ID_W-1:0]    w_first_id;

    assign w_hit_vec   = inv_mask & inv_cond & ~inv_arg0;
    assign w_hit       = |w_hit_vec;
    assign w_live      = (r_state == c_ST_ARMED) || (r_state == c_ST_FAILED);
    assign w_warm_done = (r_warm_cnt == c_WC_W'(c_WARM_LAST));
    // clear outranks a same-cycle hit, so the hit is never counted
    assign w_clr       = w_live && clear;
    assign w_take      = w_live && sample && w_hit && !clear;

    always_comb begin
        w_first_id = '0;
        for (int i = NUM_INV - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) w_first_id = ID_W'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_WARMUP: if (sample && w_warm_done) w_state_nxt = c_ST_ARMED;
            c_ST_ARMED:  if (clear) w_state_nxt = c_ST_ARMED;
                         else if (sample && w_hit) w_state_nxt = c_ST_FAILED;
            c_ST_FAILED: if (clear) w_state_nxt = c_ST_ARMED;
            default:     w_state_nxt = c_ST_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= c_ST_INIT;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_warm_cnt    <= '0;
            r_sample_cnt  <= '0;
            r_viol_pulse  <= 1'b0;
            r_viol_vec    <= '0;
            r_first_id    <= '0;
            r_first_cycle <= '0;
            r_viol_count  <= '0;
        end else begin
            r_viol_pulse <= 1'b0;
            if (sample && (r_sample_cnt != '1))
                r_sample_cnt <= r_sample_cnt + CYC_W'(1);
            if ((r_state == c_ST_WARMUP) && sample && !w_warm_done)
                r_warm_cnt <= r_warm_cnt + c_WC_W'(1);
            if (w_clr) begin
                r_viol_vec    <= '0;
                r_first_id    <= '0;
                r_first_cycle <= '0;
                r_viol_count  <= '0;
            end else if (w_take) begin
                r_viol_vec   <= r_viol_vec | w_hit_vec;
                r_viol_pulse <= 1'b1;
                if (r_viol_count != '1)
                    r_viol_count <= r_viol_count + CNT_W'(1);
                // timestamp is the pre-increment sample count
                if (r_state == c_ST_ARMED) begin
                    r_first_id    <= w_first_id;
                    r_first_cycle <= r_sample_cnt;
                end
            end
        end
    end

    assign armed       = (r_state == c_ST_ARMED);
    assign fail        = (r_state == c_ST_FAILED);
    assign viol_pulse  = r_viol_pulse;
    assign viol_vec    = r_viol_vec;
    assign first_id    = r_first_id;
    assign first_cycle = r_first_cycle;
    assign viol_count  = r_viol_count;

`ifdef INV_MON_HALT_EN
    assign halt = (r_state == c_ST_FAILED) || ((r_state == c_ST_ARMED) && w_take);
`else
    assign halt = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/invariant_monitor.md
Name: invariant_monitor

Overview:
- Consumer end of the per-invariant cond/arg0 interface produced by the Sodor 2-stage invariant block.
- Each sampled cycle it evaluates every invariant pair (violation = cond & ~arg0) and keeps sticky failure state.
- Records the first failing invariant and the sample timestamp, and counts violating cycles.
- Sits in the verification wrapper beside SodorInternalTile_2stage; its outputs feed formal assertions and simulation benches.

Parameters:
- NUM_INV, 10: number of invariant cond/arg0 pairs. Range 1..64. ID_W = max(1, clog2(NUM_INV)).
- WARMUP, 2: number of sampled cycles after reset that are ignored while pipeline registers settle. 0 means armed immediately.
- CNT_W, 16: width of the violation counter, which saturates.
- CYC_W, 32: width of the sample timestamp counter, which saturates.

Ports:
- clock  in  1  design clock.
- reset_n  in  1  reset, synchronous, active-low.
- inv_cond  in  NUM_INV  cond bit per invariant; bit i is invariant i.
- inv_arg0  in  NUM_INV  arg0 bit per invariant.
- inv_mask  in  NUM_INV  1 enables checking of invariant i; quasi-static.
- sample  in  1  evaluate the invariants this cycle; low on stalls.
- clear  in  1  acknowledge a failure and re-arm.
- armed  out  1  high in ARMED.
- fail  out  1  sticky; high in FAILED.
- viol_pulse  out  1  one-cycle registered pulse for any counted violation.
- viol_vec  out  NUM_INV  sticky OR of the masked violators since the last clear.
- first_id  out  ID_W  lowest violating index in the first failing sample.
- first_cycle  out  CYC_W  sample_cnt value at the first failure.
- viol_count  out  CNT_W  number of sampled cycles with at least one masked violation; saturates.
- halt  out  1  see Optional Feature.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State = WARMUP, or ARMED if WARMUP=0.
  - All outputs 0 except armed, which is 1 only if WARMUP=0.
  - sample_cnt = 0 and warm_cnt = 0.
- Combinational hit: hit_vec = inv_mask & inv_cond & ~inv_arg0; hit = |hit_vec.
- sample_cnt: increments on every cycle with sample=1, in all states, and saturates at all-ones.
- WARMUP:
  - Each sample increments warm_cnt.
  - When warm_cnt reaches WARMUP-1 with sample=1, go to ARMED next cycle.
  - hit is ignored; clear has no effect.
- ARMED, on sample & hit & ~clear:
  - Go to FAILED.
  - first_id = priority encode of hit_vec, lowest index wins.
  - first_cycle = current sample_cnt, the pre-increment value.
  - viol_vec |= hit_vec; viol_count += 1; viol_pulse = 1 on the next cycle.
- FAILED:
  - Further sample & hit: viol_vec |= hit_vec, viol_count increments with saturation, viol_pulse pulses.
  - first_id and first_cycle stay frozen.
- clear=1 in ARMED or FAILED:
  - Next state ARMED.
  - fail, viol_vec, viol_count, first_id and first_cycle are cleared to 0.
  - sample_cnt is not cleared and WARMUP is not re-entered.
  - clear has priority: a hit in the same cycle is dropped and not counted.
- Latency: all outputs are registered. A violation sampled at edge N is visible after edge N+1; fail, viol_pulse and first_* update together.
- sample=0: no evaluation and no counter changes; state holds.
- Saturation:
  - viol_count stays at 2^CNT_W-1; viol_pulse still pulses.
  - sample_cnt stays at 2^CYC_W-1.
- A bit of inv_mask changing mid-run affects only future samples.
- Reset asserted mid-failure wins over clear and sample, giving a full return to reset values.

Optional Feature:
- Macro INV_MON_HALT_EN.
- Defined:
  - halt is combinationally high in FAILED and also in the cycle of a qualifying ARMED hit (sample & hit & ~clear), so the core stall can be asserted with zero-cycle latency.
  - halt deasserts the cycle after clear.
- Undefined: halt is tied to 0 and no extra logic is generated.

Test Plan:
- WARMUP=2, NUM_INV=10, all mask=1:
  - Reset, then 2 samples with inv_cond[3]=1, inv_arg0[3]=0 -> no fail (ignored); armed=1 after the 2nd sample.
  - Same violation on the 3rd sample -> fail=1, first_id=3, first_cycle=2, viol_count=1, viol_pulse for 1 cycle.
- Armed; one sample with hit_vec bits 7 and 2 -> first_id=2, viol_vec=0x084; then a sample with bit 9 -> viol_vec=0x284, viol_count=2, first_id still 2.
- Hit on invariant 5 with inv_mask[5]=0 -> no fail. Hit with inv_cond[5]=0, arg0=0 -> no fail. sample=0 with hit present -> no fail and sample_cnt unchanged.
- FAILED; clear=1 and a hit on invariant 1 in the same cycle -> next cycle armed=1, fail=0, viol_count=0, viol_vec=0; the hit is dropped.
- CNT_W=2; 5 consecutive violating samples -> viol_count sequence 1,2,3,3,3, with viol_pulse high on every cycle.
- With INV_MON_HALT_EN defined: halt=1 in the cycle of the first hit, stays 1 until the cycle after clear. reset_n=0 during FAILED -> all outputs 0 next cycle. Without the macro: halt stays 0 throughout.
